bitstream_byte_feeder: RTL and testbench
========================================

# bitstream_byte_feeder

Byte-serving buffer between the upstream bitstream source and the `Decoder` arithmetic engine. It accepts 32-bit big-endian bitstream words over a valid/ready handshake and stores them in a small word FIFO. It answers the decoder's one-byte-per-pulse `request` with a registered `data`/`data_ready` reply. It replaces the simulation-only file reader on the decoder's byte-request interface, so the decoder runs on-chip against a streamed slice.

## Interface
- `FIFO_DEPTH`, 4: word FIFO depth; power of two, ≥2.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_word`  in  32  bitstream word; first byte in [31:24], last byte in [7:0].
- `in_valid`  in  1  `in_word` valid.
- `in_last`  in  1  qualifies `in_word` as the final word of the slice.
- `in_ready`  out  1  FIFO can accept a word; equals (word count < `FIFO_DEPTH`).
- `flush`  in  1  synchronous clear of all state except configuration.
- `request`  in  1  one-cycle pulse from `Decoder`: one byte wanted.
- `data`  out  8  returned byte; valid only while `data_ready`=1.
- `data_ready`  out  1  one-cycle pulse; `data` holds the requested byte.
- `level`  out  $clog2(4*FIFO_DEPTH)+1  unread bytes buffered = 4*count − byte_ptr.
- `eos`  out  1  sticky: the `in_last` word has been fully consumed.
- `underrun`  out  1  sticky: a request was dropped (see Operation).

## Operation
- Word accepted when `in_valid && in_ready` at a rising edge. `in_last` is stored with the word.
- The head word is read through a 2-bit `byte_ptr`, which selects byte [31:24], then [23:16], [15:8], [7:0].
- Serving a byte: `data <= head[byte_ptr]`, `data_ready <= 1` and `byte_ptr` increments. When `byte_ptr` is 3 it wraps to 0 and the head word pops. If the popped word carried `in_last`, `eos` is set.
- State machine:
  - IDLE: no request outstanding.
    - `request` with `level`>0: serve, stay in IDLE.
    - `request` with `level`=0 and `eos`=0: go to WAIT.
    - `request` with `level`=0 and `eos`=1: handled per Configuration.
  - WAIT: one request pending.
    - When count>0 (registered): serve, go to IDLE.
    - A further `request` while in WAIT is dropped and sets `underrun`.
- Push and pop in the same cycle are allowed. Count is unchanged, and `in_ready` is computed from the registered count only. A full FIFO therefore refuses a push even in a popping cycle.
- Words accepted after `eos` is set are buffered normally. `eos` is cleared only by `flush` or `reset`.
- `flush`:
  - takes priority over `request` and `in_valid` in the same cycle;
  - empties the FIFO, zeroes `byte_ptr`, returns to IDLE, and clears `eos` and `underrun`;
  - forces `data_ready`=0 in the following cycle.
- Reset values: `data`=8'h00, `data_ready`=0, `level`=0, `eos`=0, `underrun`=0, `in_ready`=1, state IDLE, `byte_ptr`=0.
- Reset asserted mid-transfer discards all buffered bytes and any pending request immediately (asynchronous).

## Timing
- Hit latency: `request` high in cycle t with `level`>0 gives `data_ready` high in cycle t+1, for exactly one cycle.
- Back-to-back `request` pulses on consecutive cycles with bytes buffered give `data_ready` on consecutive cycles. Sustained throughput is 1 byte/cycle.
- Miss latency: a word accepted at edge e with state WAIT gives a serve at edge e+1, so `data_ready` is high in the cycle after e+1.
- `level` and `in_ready` update at the same edge as the push/pop that changes them.

## Configuration
- `FEEDER_ZERO_PAD_EN` defined: a `request` in IDLE with `level`=0 and `eos`=1 is served with `data`=8'h00 and `data_ready` at t+1. This is the trailing-zero convention for reads past the slice end. The state stays in IDLE.
- Not defined: that request goes to WAIT like any other miss and stalls until a new word arrives. No zero bytes are ever generated.

## Test plan
- Reset then push 32'hA1B2C3D4, then 4 `request` pulses on consecutive cycles → `data`=A1,B2,C3,D4 on 4 consecutive `data_ready` cycles, `level` 4→0.
- Fill 4 words (0x00010203..0x0C0D0E0F) → `in_ready`=0, `level`=16. A 5th `in_valid` is held off until the first pop, after which the 5th word is accepted.
- `request` with empty FIFO, then push 32'h5A000000 three cycles later → a single `data_ready` with `data`=5A, 2 cycles after the accept edge. A second `request` during the wait sets `underrun`=1.
- Push 32'h11223344 with `in_last`=1 and consume 4 bytes → `eos`=1 after the 4th serve. A 5th `request` returns 00 with the macro defined, and gives no `data_ready` for 10 cycles without it.
- With 2 words buffered and `byte_ptr`=2, assert `flush` together with `request` → no `data_ready`, `level`=0, `eos`=0, `underrun`=0, `in_ready`=1 next cycle.
- Assert `reset` asynchronously between edges while in WAIT → outputs reach their reset values without a clock edge. A later push followed by `request` behaves as from power-up.

Source files
------------

// File: rtl/bitstream_byte_feeder_if.sv
// Byte-feeder bus: upstream word handshake plus the decoder byte-request reply.
interface bitstream_byte_feeder_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LEVEL_W = $clog2(4 * FIFO_DEPTH) + 1;

  logic [31:0]        in_word;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic               flush;
  logic               request;
  logic [7:0]         data;
  logic               data_ready;
  logic [LEVEL_W-1:0] level;
  logic               eos;
  logic               underrun;

  modport master (
    output in_word, in_valid, in_last, flush, request,
    input  in_ready, data, data_ready, level, eos, underrun
  );

  modport slave (
    input  in_word, in_valid, in_last, flush, request,
    output in_ready, data, data_ready, level, eos, underrun
  );
endinterface

// File: rtl/bitstream_byte_feeder.sv
// Word FIFO serving big-endian bytes to the decoder, one per request pulse.
// Optional FEEDER_ZERO_PAD_EN: requests past end-of-slice return 8'h00.
module bitstream_byte_feeder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  bitstream_byte_feeder_if.slave  bus
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = $clog2(4 * FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [31:0]           mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0]            byte_ptr_q, byte_ptr_d;
  logic [0:0]            state_q, state_d;
  logic [7:0]            data_q, data_d;
  logic                  data_ready_q, data_ready_d;
  logic                  eos_q, eos_d;
  logic                  underrun_q, underrun_d;

  logic                  in_ready;
  logic                  push;
  logic                  pop;
  logic                  serve;
  logic                  pad;
  logic [7:0]            head_byte;
  logic [31:0]           head_word;

  // Registered count only: a full FIFO refuses a push even while popping.
  assign in_ready = (count_q != DEPTH_C);

  assign head_word = mem_q[rd_ptr_q];

  always_comb begin
    head_byte = '0;
    case (byte_ptr_q)
      2'd0:    head_byte = head_word[31:24];
      2'd1:    head_byte = head_word[23:16];
      2'd2:    head_byte = head_word[15:8];
      default: head_byte = head_word[7:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    byte_ptr_d   = byte_ptr_q;
    data_d       = data_q;
    data_ready_d = 1'b0;
    eos_d        = eos_q;
    underrun_d   = underrun_q;
    serve        = 1'b0;
    pad          = 1'b0;
    push         = 1'b0;

    if (bus.flush) begin
      state_d    = S_IDLE;
      byte_ptr_d = '0;
      data_d     = '0;
      eos_d      = 1'b0;
      underrun_d = 1'b0;
    end else begin
      push = bus.in_valid && in_ready;
      case (state_q)
        S_IDLE: begin
          if (bus.request) begin
            if (count_q != '0) begin
              serve = 1'b1;
            end else if (eos_q) begin
`ifdef FEEDER_ZERO_PAD_EN
              pad = 1'b1;
`else
              state_d = S_WAIT;
`endif
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        default: begin
          if (count_q != '0) begin
            serve   = 1'b1;
            state_d = S_IDLE;
          end
          if (bus.request) begin
            underrun_d = 1'b1;
          end
        end
      endcase

      if (serve) begin
        data_d       = head_byte;
        data_ready_d = 1'b1;
        byte_ptr_d   = byte_ptr_q + 2'd1;
        if ((byte_ptr_q == 2'd3) && last_q[rd_ptr_q]) begin
          eos_d = 1'b1;
        end
      end else if (pad) begin
        data_d       = '0;
        data_ready_d = 1'b1;
      end
    end
  end

  assign pop = serve && (byte_ptr_q == 2'd3);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      byte_ptr_q   <= '0;
      state_q      <= S_IDLE;
      data_q       <= '0;
      data_ready_q <= 1'b0;
      eos_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      byte_ptr_q   <= byte_ptr_d;
      state_q      <= state_d;
      data_q       <= data_d;
      data_ready_q <= data_ready_d;
      eos_q        <= eos_d;
      underrun_q   <= underrun_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]  <= bus.in_word;
      last_q[wr_ptr_q] <= bus.in_last;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.data       = data_q;
  assign bus.data_ready = data_ready_q;
  assign bus.level      = {count_q, 2'b00} - LW'(byte_ptr_q);
  assign bus.eos        = eos_q;
  assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_bitstream_byte_feeder.sv
// Scoreboard bench for bitstream_byte_feeder: expected bytes queued at request time.
module tb_bitstream_byte_feeder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bitstream_byte_feeder_if #(.FIFO_DEPTH(4)) bus ();

  bitstream_byte_feeder #(.FIFO_DEPTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_word  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.flush    = 1'b0;
    bus.request  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    tick();
    exp_q.delete();
  endtask

  // Every delivered byte is compared against the oldest expected one.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.data_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_byte: got data_ready=1 data=%02h, required no reply", bus.data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.data !== mon_exp)
          $display("FAIL byte_value: got %02h, required %02h", bus.data, mon_exp);
        else
          n_pass++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();
    n_checks++; if (bus.data !== 8'h00) $display("FAIL rst_data: got %02h, required 00", bus.data); else n_pass++;
    n_checks++; if (bus.data_ready !== 1'b0) $display("FAIL rst_data_ready: got %b, required 0", bus.data_ready); else n_pass++;
    n_checks++; if (bus.level !== 5'd0) $display("FAIL rst_level: got %0d, required 0", bus.level); else n_pass++;
    n_checks++; if (bus.eos !== 1'b0 || bus.underrun !== 1'b0) $display("FAIL rst_flags: got eos=%b underrun=%b, required 0/0", bus.eos, bus.underrun); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b, required 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_hit();
    logic [31:0] w;
    do_reset();
    w = 32'hA1B2C3D4;
    bus.in_word = w; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.level !== 5'd4) $display("FAIL hit_level_push: got %0d, required 4", bus.level); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus.request = 1'b1;
      exp_q.push_back(w[31-8*i -: 8]);
      tick();
      n_checks++; if (bus.data_ready !== 1'b1) $display("FAIL hit_latency[%0d]: got data_ready=%b, required 1", i, bus.data_ready); else n_pass++;
      n_checks++; if (bus.level !== 5'(3 - i)) $display("FAIL hit_level[%0d]: got %0d, required %0d", i, bus.level, 3 - i); else n_pass++;
    end
    bus.request = 1'b0;
    tick();
    n_checks++; if (bus.data_ready !== 1'b0) $display("FAIL hit_single_pulse: got %b, required 0", bus.data_ready); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL hit_drained: got %0d pending, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_fill_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.in_word  = 32'h00010203 + 32'(i) * 32'h04040404;
      bus.in_valid = 1'b1;
      tick();
    end
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b, required 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.level !== 5'd16) $display("FAIL fill_level: got %0d, required 16", bus.level); else n_pass++;
    bus.in_word = 32'h10111213;
    repeat (2) tick();
    n_checks++; if (bus.level !== 5'd16) $display("FAIL fill_held_off: got level %0d, required 16", bus.level); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus.request = 1'b1;
      exp_q.push_back(8'(i));
      tick();
    end
    bus.request = 1'b0;
    n_checks++; if (bus.level !== 5'd12 || bus.in_ready !== 1'b1) $display("FAIL fill_pop_no_push: got level=%0d in_ready=%b, required 12/1", bus.level, bus.in_ready); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.level !== 5'd16 || bus.in_ready !== 1'b0) $display("FAIL fill_fifth_accept: got level=%0d in_ready=%b, required 16/0", bus.level, bus.in_ready); else n_pass++;
    for (int i = 4; i < 20; i++) begin
      bus.request = 1'b1;
      exp_q.push_back(8'(i));
      tick();
    end
    bus.request = 1'b0;
    tick();
    n_checks++; if (bus.level !== 5'd0 || exp_q.size() != 0) $display("FAIL fill_drain: got level=%0d pending=%0d, required 0/0", bus.level, exp_q.size()); else n_pass++;
  endtask

  task automatic test_miss();
    do_reset();
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
    n_checks++; if (bus.data_ready !== 1'b0) $display("FAIL miss_no_reply: got %b, required 0", bus.data_ready); else n_pass++;
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
    n_checks++; if (bus.underrun !== 1'b1) $display("FAIL miss_underrun: got %b, required 1", bus.underrun); else n_pass++;
    tick();
    bus.in_word = 32'h5A000000; bus.in_valid = 1'b1;
    exp_q.push_back(8'h5A);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.data_ready !== 1'b0 || bus.level !== 5'd4) $display("FAIL miss_accept_edge: got dr=%b level=%0d, required 0/4", bus.data_ready, bus.level); else n_pass++;
    tick();
    n_checks++; if (bus.data_ready !== 1'b1 || bus.level !== 5'd3) $display("FAIL miss_latency: got dr=%b level=%0d, required 1/3", bus.data_ready, bus.level); else n_pass++;
    tick();
    n_checks++; if (bus.data_ready !== 1'b0) $display("FAIL miss_single_reply: got %b, required 0", bus.data_ready); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL miss_drained: got %0d pending, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_eos();
    logic [31:0] w;
    logic        seen;
    do_reset();
    w = 32'h11223344;
    bus.in_word = w; bus.in_valid = 1'b1; bus.in_last = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.request = 1'b1;
      exp_q.push_back(w[31-8*i -: 8]);
      tick();
      n_checks++; if (bus.eos !== (i == 3)) $display("FAIL eos_timing[%0d]: got %b, required %b", i, bus.eos, (i == 3)); else n_pass++;
    end
    bus.request = 1'b1;
`ifdef FEEDER_ZERO_PAD_EN
    exp_q.push_back(8'h00);
    tick();
    bus.request = 1'b0;
    n_checks++; if (bus.data_ready !== 1'b1 || bus.data !== 8'h00) $display("FAIL eos_zero_pad: got dr=%b data=%02h, required 1/00", bus.data_ready, bus.data); else n_pass++;
    tick();
    n_checks++; if (bus.level !== 5'd0) $display("FAIL eos_pad_level: got %0d, required 0", bus.level); else n_pass++;
`else
    tick();
    bus.request = 1'b0;
    seen = bus.data_ready;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.data_ready === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL eos_stall: got a data_ready within 10 cycles, required none"); else n_pass++;
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
    n_checks++; if (bus.underrun !== 1'b1) $display("FAIL eos_underrun: got %b, required 1", bus.underrun); else n_pass++;
    bus.in_word = 32'hAB000000; bus.in_valid = 1'b1;
    exp_q.push_back(8'hAB);
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (bus.data_ready !== 1'b1) $display("FAIL eos_resume: got dr=%b, required 1", bus.data_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      bus.request = 1'b1;
      exp_q.push_back(8'h00);
      tick();
    end
    bus.request = 1'b0;
    tick();
    n_checks++; if (bus.level !== 5'd0) $display("FAIL eos_drain_level: got %0d, required 0", bus.level); else n_pass++;
`endif
    n_checks++; if (bus.eos !== 1'b1) $display("FAIL eos_sticky: got %b, required 1", bus.eos); else n_pass++;
  endtask

  task automatic test_flush();
    bus.in_word = 32'h01020304; bus.in_valid = 1'b1;
    tick();
    bus.in_word = 32'h05060708;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      bus.request = 1'b1;
      exp_q.push_back(8'(i));
      tick();
    end
    n_checks++; if (bus.level !== 5'd6) $display("FAIL flush_pre_level: got %0d, required 6", bus.level); else n_pass++;
    bus.flush = 1'b1; bus.request = 1'b1;
    bus.in_word = 32'hDEADBEEF; bus.in_valid = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (bus.data_ready !== 1'b0) $display("FAIL flush_data_ready: got %b, required 0", bus.data_ready); else n_pass++;
    n_checks++; if (bus.level !== 5'd0 || bus.in_ready !== 1'b1) $display("FAIL flush_fifo: got level=%0d in_ready=%b, required 0/1", bus.level, bus.in_ready); else n_pass++;
    n_checks++; if (bus.eos !== 1'b0 || bus.underrun !== 1'b0) $display("FAIL flush_flags: got eos=%b underrun=%b, required 0/0", bus.eos, bus.underrun); else n_pass++;
    bus.in_word = 32'h77665544; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.data_ready !== 1'b0) $display("FAIL flush_no_wait: got %b, required 0", bus.data_ready); else n_pass++;
    bus.request = 1'b1;
    exp_q.push_back(8'h77);
    tick();
    bus.request = 1'b0;
    n_checks++; if (bus.level !== 5'd3) $display("FAIL flush_ptr_zeroed: got level %0d, required 3", bus.level); else n_pass++;
    tick();
    n_checks++; if (exp_q.size() != 0) $display("FAIL flush_drained: got %0d pending, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    do_reset();
    bus.in_word = 32'h0102030F; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.request = 1'b1;
      exp_q.push_back((i == 4) ? 8'h0F : 8'(i));
      tick();
    end
    bus.request = 1'b1;
    tick();
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
    n_checks++; if (bus.underrun !== 1'b1 || bus.data !== 8'h0F) $display("FAIL ar_pre: got underrun=%b data=%02h, required 1/0f", bus.underrun, bus.data); else n_pass++;
    #3 reset = 1'b1;
    #1;
    n_checks++; if (bus.underrun !== 1'b0 || bus.data !== 8'h00 || bus.data_ready !== 1'b0) $display("FAIL ar_async_outputs: got underrun=%b data=%02h dr=%b, required 0/00/0", bus.underrun, bus.data, bus.data_ready); else n_pass++;
    n_checks++; if (bus.level !== 5'd0 || bus.in_ready !== 1'b1 || bus.eos !== 1'b0) $display("FAIL ar_async_status: got level=%0d in_ready=%b eos=%b, required 0/1/0", bus.level, bus.in_ready, bus.eos); else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    w = 32'h9ABCDEF0;
    bus.in_word = w; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (bus.data_ready !== 1'b0 || bus.level !== 5'd4) $display("FAIL ar_pending_dropped: got dr=%b level=%0d, required 0/4", bus.data_ready, bus.level); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus.request = 1'b1;
      exp_q.push_back(w[31-8*i -: 8]);
      tick();
    end
    bus.request = 1'b0;
    tick();
    n_checks++; if (exp_q.size() != 0 || bus.level !== 5'd0) $display("FAIL ar_replay: got pending=%0d level=%0d, required 0/0", exp_q.size(), bus.level); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_hit();
    test_fill_back_to_back();
    test_miss();
    test_eos();
    test_flush();
    test_async_reset();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "time limit");
  end
endmodule
